// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multicycle sequencer: estado codes, opcode classes, error codes.
package multicycle_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b1000,
    ST_FETCH   = 4'b0001,
    ST_DECODE  = 4'b0010,
    ST_EXECUTE = 4'b0011,
    ST_COMMIT  = 4'b1111,
    ST_NEXTPC  = 4'b0100,
    ST_HALT    = 4'b1110
  } estado_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_TIPO = 2'b01,
    ERR_IMEM = 2'b10,
    ERR_DMEM = 2'b11
  } err_e;

  localparam logic [2:0] TIPO_LW   = 3'b000;
  localparam logic [2:0] TIPO_ADDI = 3'b001;
  localparam logic [2:0] TIPO_SW   = 3'b010;
  localparam logic [2:0] TIPO_R    = 3'b011;
  localparam logic [2:0] TIPO_BEQ  = 3'b110;

  function automatic logic tipo_legal(input logic [2:0] t);
    return (t == TIPO_LW) || (t == TIPO_ADDI) || (t == TIPO_SW) ||
           (t == TIPO_R)  || (t == TIPO_BEQ);
  endfunction

  function automatic logic tipo_is_mem(input logic [2:0] t);
    return (t == TIPO_LW) || (t == TIPO_SW);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Memory wait timer: counts not-ready cycles and flags the cycle that exhausts the budget.
module multicycle_sequencer_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  input  logic ready,
  output logic timeout
);

  localparam int unsigned W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Ready in the final budgeted cycle still wins over the timeout.
  assign timeout = count_en && !ready && (cnt_q == W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle RISC-V state sequencer: fetch/decode/execute/commit/next-PC with memory waits and halt.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop_req,
  input  logic [2:0]       tipo,
  input  logic             br_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic [3:0]       estado,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instr_count
);

  estado_e            state_q, state_d;
  logic               stop_q, stop_d;
  logic               br_q, br_d;
  logic [1:0]         err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wait_en, wait_rdy, wait_clr, timeout;

  assign wait_en  = (state_q == ST_FETCH) || ((state_q == ST_COMMIT) && tipo_is_mem(tipo));
  assign wait_rdy = (state_q == ST_FETCH) ? imem_ready : dmem_ready;
  assign wait_clr = (state_d != state_q);

  multicycle_sequencer_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (wait_clr),
    .count_en (wait_en),
    .ready    (wait_rdy),
    .timeout  (timeout)
  );

  always_comb begin
    state_d  = state_q;
    stop_d   = stop_q;
    br_d     = br_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    halted   = 1'b0;

    if (stop_req && (state_q != ST_IDLE) && (state_q != ST_HALT)) begin
      stop_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_HALT;
          err_d   = ERR_IMEM;
        end
      end
      ST_DECODE: begin
        if (tipo_legal(tipo)) begin
          state_d = ST_EXECUTE;
        end else begin
          state_d = ST_HALT;
          err_d   = ERR_TIPO;
        end
      end
      ST_EXECUTE: begin
        br_d    = br_taken && (tipo == TIPO_BEQ);
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (tipo_is_mem(tipo)) begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            state_d = ST_NEXTPC;
          end else if (timeout) begin
            state_d = ST_HALT;
            err_d   = ERR_DMEM;
          end
        end else begin
          state_d = ST_NEXTPC;
        end
      end
      ST_NEXTPC: begin
        pc_write = 1'b1;
        pc_sel   = br_q;
        cnt_d    = cnt_q + 1'b1;
        // A stop arriving in this very cycle is honoured immediately.
        stop_d   = 1'b0;
        state_d  = (stop_q || stop_req) ? ST_IDLE : ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stop_q  <= 1'b0;
      br_q    <= 1'b0;
      err_q   <= ERR_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      br_q    <= br_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign estado      = state_q;
  assign err_code    = err_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: instruction-level model expands each instruction into expected cycles.
module tb_multicycle_sequencer;

  localparam int unsigned MT = 4;
  localparam int          CW = 32;

  localparam logic [3:0] E_IDLE = 4'b1000, E_FETCH = 4'b0001, E_DECODE = 4'b0010,
                         E_EXEC = 4'b0011, E_COMMIT = 4'b1111, E_NEXTPC = 4'b0100,
                         E_HALT = 4'b1110;

  logic          clk = 1'b0;
  logic          rst_n, start, stop_req, br_taken, imem_ready, dmem_ready;
  logic [2:0]    tipo;
  logic [3:0]    estado;
  logic          imem_req, ir_load, dmem_req, pc_write, pc_sel, halted;
  logic [1:0]    err_code;
  logic [CW-1:0] instr_count;

  multicycle_sequencer #(
    .MEM_TIMEOUT(MT),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop_req   (stop_req),
    .tipo       (tipo),
    .br_taken   (br_taken),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .estado     (estado),
    .imem_req   (imem_req),
    .ir_load    (ir_load),
    .dmem_req   (dmem_req),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .halted     (halted),
    .err_code   (err_code),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rn, st, sr;
    logic [2:0]    tp;
    logic          br, ir, dr;
    logic [3:0]    es;
    logic          imr, irl, dmr, pcw, pcs, hlt;
    logic [1:0]    err;
    logic [CW-1:0] cnt;
  } rec_t;

  rec_t sched[$];

  int unsigned m_cnt;
  logic [1:0]  m_err;
  bit          m_tie, m_start;

  int checks = 0, failures = 0, cyc = 0;
  int pcw_seen, pcs_seen, dmr_seen, last_pcw, cpi_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input logic rn, input logic sr, input logic [2:0] tp, input logic br,
                      input logic ir, input logic dr, input logic [3:0] es, input logic imr,
                      input logic irl, input logic dmr, input logic pcw, input logic pcs,
                      input logic hlt);
    rec_t r;
    r.rn = rn; r.st = m_start; r.sr = sr; r.tp = tp; r.br = br; r.ir = ir; r.dr = dr;
    r.es = es; r.imr = imr; r.irl = irl; r.dmr = dmr; r.pcw = pcw; r.pcs = pcs; r.hlt = hlt;
    r.err = m_err; r.cnt = CW'(m_cnt);
    sched.push_back(r);
  endtask

  task automatic m_reset();
    m_cnt = 0; m_err = 2'b00; m_start = 1'b0;
    push(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic m_idle(input int n, input bit st, input bit sr);
    m_start = st;
    repeat (n) push(1'b1, sr, 3'b000, 1'b0, m_tie, m_tie, E_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic m_halt(input int n);
    for (int i = 0; i < n; i++) begin
      m_start = i[0];
      push(1'b1, i[0], 3'b111, 1'b0, 1'b1, 1'b1, E_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  // One instruction: iw/dw are imem/dmem wait cycles, stop_at 1=pulse in EXECUTE, 2=in NEXTPC.
  task automatic m_instr(input logic [2:0] tp, input int iw, input int dw, input bit br,
                         input int stop_at, input bit abort_commit);
    bit rdy;
    bit mem;
    mem = (tp == 3'b000) || (tp == 3'b010);
    m_start = 1'b1;
    for (int k = 0; k < int'(MT); k++) begin
      rdy = (k == iw);
      push(1'b1, 1'b0, tp, 1'b0, rdy, m_tie, E_FETCH, 1'b1, rdy, 1'b0, 1'b0, 1'b0, 1'b0);
      if (rdy) break;
      if (k == int'(MT) - 1) begin
        m_err = 2'b10;
        return;
      end
    end
    push(1'b1, 1'b0, tp, 1'b0, m_tie, m_tie, E_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (!(tp inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b110})) begin
      m_err = 2'b01;
      return;
    end
    push(1'b1, stop_at == 1, tp, br, m_tie, m_tie, E_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (abort_commit) begin
      m_cnt = 0; m_err = 2'b00; m_start = 1'b0;
      push(1'b0, 1'b0, tp, 1'b0, 1'b0, 1'b0, E_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      return;
    end
    if (mem) begin
      for (int k = 0; k < int'(MT); k++) begin
        rdy = (k == dw);
        push(1'b1, 1'b0, tp, 1'b0, m_tie, rdy, E_COMMIT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        if (rdy) break;
        if (k == int'(MT) - 1) begin
          m_err = 2'b11;
          return;
        end
      end
    end else begin
      push(1'b1, 1'b0, tp, 1'b0, m_tie, m_tie, E_COMMIT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    push(1'b1, stop_at == 2, tp, 1'b0, m_tie, m_tie, E_NEXTPC, 1'b0, 1'b0, 1'b0, 1'b1,
         br && (tp == 3'b110), 1'b0);
    m_cnt++;
  endtask

  task automatic clear_tally();
    pcw_seen = 0; pcs_seen = 0; dmr_seen = 0; last_pcw = cyc; cpi_last = 0;
  endtask

  task automatic run_sched();
    rec_t r;
    while (sched.size() > 0) begin
      r = sched.pop_front();
      @(posedge clk);
      #1;
      rst_n = r.rn; start = r.st; stop_req = r.sr; tipo = r.tp;
      br_taken = r.br; imem_ready = r.ir; dmem_ready = r.dr;
      @(negedge clk);
      cyc++;
      chk("estado",      32'(estado),      32'(r.es));
      chk("imem_req",    32'(imem_req),    32'(r.imr));
      chk("ir_load",     32'(ir_load),     32'(r.irl));
      chk("dmem_req",    32'(dmem_req),    32'(r.dmr));
      chk("pc_write",    32'(pc_write),    32'(r.pcw));
      chk("pc_sel",      32'(pc_sel),      32'(r.pcs));
      chk("halted",      32'(halted),      32'(r.hlt));
      chk("err_code",    32'(err_code),    32'(r.err));
      chk("instr_count", 32'(instr_count), 32'(r.cnt));
      if (pc_write === 1'b1) begin
        pcw_seen++;
        if (pc_sel === 1'b1) pcs_seen++;
        cpi_last = cyc - last_pcw;
        last_pcw = cyc;
      end
      if (dmem_req === 1'b1) dmr_seen++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop_req = 1'b0; tipo = 3'b000;
    br_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    m_tie = 1'b0; m_start = 1'b0; m_cnt = 0; m_err = 2'b00;
    clear_tally();

    // Back-to-back addi with readies tied high; stop coincides with third NEXTPC.
    m_reset();
    m_tie = 1'b1;
    m_idle(1, 1'b1, 1'b0);
    m_instr(3'b001, 0, 0, 1'b0, 0, 1'b0);
    m_instr(3'b001, 0, 0, 1'b0, 0, 1'b0);
    m_instr(3'b001, 0, 0, 1'b0, 2, 1'b0);
    m_idle(1, 1'b0, 1'b0);
    clear_tally();
    run_sched();
    chk("t1_pc_writes", 32'(pcw_seen), 32'd3);
    chk("t1_count", instr_count, 32'd3);
    chk("t1_cpi", 32'(cpi_last), 32'd5);

    // lw with 3 dmem wait cycles, then sw with imem waits.
    m_tie = 1'b0;
    m_idle(1, 1'b1, 1'b0);
    m_instr(3'b000, 0, 3, 1'b0, 0, 1'b0);
    m_instr(3'b000, 0, 3, 1'b0, 2, 1'b0);
    m_idle(1, 1'b0, 1'b0);
    clear_tally();
    run_sched();
    chk("t2_cpi", 32'(cpi_last), 32'd8);
    chk("t2_dmem_req_cycles", 32'(dmr_seen), 32'd8);
    chk("t2_count", instr_count, 32'd5);
    m_idle(1, 1'b1, 1'b0);
    m_instr(3'b010, 2, 0, 1'b0, 2, 1'b0);
    m_idle(1, 1'b0, 1'b0);
    run_sched();

    // beq taken / not taken; stop in IDLE ignored; stop pulse in EXECUTE.
    m_idle(1, 1'b0, 1'b1);
    m_idle(1, 1'b1, 1'b0);
    m_instr(3'b110, 0, 0, 1'b1, 0, 1'b0);
    m_instr(3'b110, 1, 0, 1'b0, 1, 1'b0);
    m_idle(2, 1'b0, 1'b0);
    clear_tally();
    run_sched();
    chk("t3_pc_sel_taken", 32'(pcs_seen), 32'd1);
    chk("t3_count", instr_count, 32'd8);
    m_idle(1, 1'b1, 1'b0);
    m_instr(3'b011, 0, 0, 1'b1, 0, 1'b0);
    m_instr(3'b001, 0, 0, 1'b0, 2, 1'b0);
    m_idle(1, 1'b0, 1'b0);
    run_sched();
    chk("t3_count_after", instr_count, 32'd10);

    // Illegal tipo halts; start/stop toggling has no effect.
    m_idle(1, 1'b1, 1'b0);
    m_instr(3'b111, 0, 0, 1'b0, 0, 1'b0);
    m_halt(4);
    run_sched();
    chk("t4_estado", 32'(estado), 32'hE);
    chk("t4_err", 32'(err_code), 32'd1);

    // imem timeout; ready on last budgeted cycle succeeds; dmem timeout.
    m_reset();
    m_idle(1, 1'b1, 1'b0);
    m_instr(3'b001, 4, 0, 1'b0, 0, 1'b0);
    m_halt(2);
    run_sched();
    chk("t5_imem_timeout_err", 32'(err_code), 32'd2);
    m_reset();
    m_idle(1, 1'b1, 1'b0);
    m_instr(3'b001, 3, 0, 1'b0, 2, 1'b0);
    m_idle(1, 1'b0, 1'b0);
    m_idle(1, 1'b1, 1'b0);
    m_instr(3'b000, 0, 4, 1'b0, 0, 1'b0);
    m_halt(2);
    run_sched();
    chk("t5_dmem_timeout_err", 32'(err_code), 32'd3);
    chk("t5_count", instr_count, 32'd1);

    // Reset during COMMIT aborts without a PC write.
    m_reset();
    m_idle(1, 1'b1, 1'b0);
    m_instr(3'b000, 0, 2, 1'b0, 0, 1'b1);
    m_idle(2, 1'b0, 1'b0);
    clear_tally();
    run_sched();
    chk("t6_no_pc_write", 32'(pcw_seen), 32'd0);
    chk("t6_count", instr_count, 32'd0);
    chk("t6_estado", 32'(estado), 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
